cv32e_obi_port_mux: RTL and testbench

Parametrised successor to the single instruction-to-data port adapter. Arbitrates NUM_PORTS CV32E-style request ports (instruction and/or data) onto one CORE_DATA-style master port. Tracks outstanding transactions in an in-order ID FIFO so responses are routed back to the issuing port. Sits between the core's fetch/LSU ports and the shared SoC data bus; ports flagged read-only get instruction-fetch semantics.

---
 rtl/cv32e_obi_port_mux.sv | 142 ++++++++++++++
 tb/tb_cv32e_obi_port_mux.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e_obi_port_mux.sv
// Arbitrates NUM_PORTS OBI request ports onto one master port and routes
// in-order responses back to the issuing port through an ID FIFO.
module cv32e_obi_port_mux #(
  parameter int NUM_PORTS       = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ARB_MODE        = 1,
  parameter logic [NUM_PORTS-1:0] READ_ONLY_MASK = 'b01,
  localparam int BE_W  = DATA_W / 8,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUM_PORTS-1:0]        s_req_i,
  input  logic [NUM_PORTS*ADDR_W-1:0] s_addr_i,
  input  logic [NUM_PORTS-1:0]        s_we_i,
  input  logic [NUM_PORTS*BE_W-1:0]   s_be_i,
  input  logic [NUM_PORTS*DATA_W-1:0] s_wdata_i,
  output logic [NUM_PORTS-1:0]        s_gnt_o,
  output logic [NUM_PORTS-1:0]        s_rvalid_o,
  output logic [DATA_W-1:0]           s_rdata_o,
  output logic                        m_data_req_o,
  output logic [ADDR_W-1:0]           m_data_addr_o,
  output logic                        m_data_we_o,
  output logic [BE_W-1:0]             m_data_be_o,
  output logic [DATA_W-1:0]           m_data_wdata_o,
  input  logic                        m_data_gnt_i,
  input  logic                        m_data_rvalid_i,
  input  logic [DATA_W-1:0]           m_data_rdata_i,
  output logic [CNT_W-1:0]            outstanding_o,
  output logic                        protocol_err_o
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int FW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [PW-1:0]  r_fifo [MAX_OUTSTANDING];
  logic [FW-1:0]  r_wr_ptr;
  logic [FW-1:0]  r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic           r_lock_vld;
  logic [PW-1:0]  r_lock_idx;
  logic [PW-1:0]  r_rr_ptr;
  logic           r_err;

  logic [PW-1:0]  w_win;
  logic [PW-1:0]  w_idx;
  logic           w_found;
  logic [PW-1:0]  w_sel;
  logic [PW-1:0]  w_head;
  logic           w_full;
  logic           w_empty;
  logic           w_grant;
  logic           w_pop;

  // Winner search: fixed priority favours the lowest index, round-robin
  // starts at the pointer and wraps.
  always_comb begin
    w_win   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (ARB_MODE == 0) w_idx = PW'(k);
      else               w_idx = PW'((int'(r_rr_ptr) + k) % NUM_PORTS);
      if (!w_found && s_req_i[w_idx]) begin
        w_win   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign w_sel   = r_lock_vld ? r_lock_idx : w_win;
  assign w_full  = (r_count == CNT_W'(MAX_OUTSTANDING));
  assign w_empty = (r_count == '0);
  assign w_head  = r_fifo[r_rd_ptr];

  assign m_data_req_o = (|s_req_i) && !w_full;
  assign w_grant      = m_data_gnt_i && m_data_req_o;
  assign w_pop        = m_data_rvalid_i && !w_empty;

  always_comb begin
    m_data_addr_o = s_addr_i[w_sel*ADDR_W +: ADDR_W];
    if (READ_ONLY_MASK[w_sel]) begin
      m_data_we_o    = 1'b0;
      m_data_be_o    = '1;
      m_data_wdata_o = '0;
    end else begin
      m_data_we_o    = s_we_i[w_sel];
      m_data_be_o    = s_be_i[w_sel*BE_W +: BE_W];
      m_data_wdata_o = s_wdata_i[w_sel*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    s_gnt_o           = '0;
    s_gnt_o[w_sel]    = w_grant;
    s_rvalid_o        = '0;
    s_rvalid_o[w_head] = w_pop;
  end

  assign s_rdata_o      = m_data_rdata_i;
  assign outstanding_o  = r_count;
  assign protocol_err_o = r_err;

  // Lock holds the selected port stable while the master stalls its grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lock_vld <= 1'b0;
      r_lock_idx <= '0;
      r_rr_ptr   <= '0;
    end else if (w_grant) begin
      r_lock_vld <= 1'b0;
      if (ARB_MODE != 0)
        r_rr_ptr <= (w_sel == PW'(NUM_PORTS - 1)) ? '0 : w_sel + 1'b1;
    end else if (m_data_req_o) begin
      r_lock_vld <= 1'b1;
      r_lock_idx <= w_sel;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) r_fifo[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_grant) begin
        r_fifo[r_wr_ptr] <= w_sel;
        r_wr_ptr <= (r_wr_ptr == FW'(MAX_OUTSTANDING - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop)
        r_rd_ptr <= (r_rd_ptr == FW'(MAX_OUTSTANDING - 1)) ? '0 : r_rd_ptr + 1'b1;
      if (w_grant && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_grant && w_pop) r_count <= r_count - 1'b1;
      if (m_data_rvalid_i && w_empty) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cv32e_obi_port_mux.sv
// Directed bench for cv32e_obi_port_mux: round-robin instance fully checked,
// fixed-priority instance checked under contention.
module tb_cv32e_obi_port_mux;

  logic        clk;
  logic        rst_n;
  logic [1:0]  s_req;
  logic [63:0] s_addr;
  logic [1:0]  s_we;
  logic [7:0]  s_be;
  logic [63:0] s_wdata;
  logic        m_gnt;
  logic        m_rvalid;
  logic [31:0] m_rdata;

  logic [1:0]  gnt, rvalid;
  logic [31:0] rdata;
  logic        m_req, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  logic [2:0]  outst;
  logic        perr;

  logic [1:0]  fp_gnt, fp_rvalid;
  logic [31:0] fp_rdata, fp_addr, fp_wdata;
  logic        fp_req, fp_we, fp_perr;
  logic [3:0]  fp_be;
  logic [2:0]  fp_outst;

  int checks = 0;
  int failures = 0;

  cv32e_obi_port_mux #(.ARB_MODE(1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .s_req_i(s_req), .s_addr_i(s_addr), .s_we_i(s_we), .s_be_i(s_be), .s_wdata_i(s_wdata),
    .s_gnt_o(gnt), .s_rvalid_o(rvalid), .s_rdata_o(rdata),
    .m_data_req_o(m_req), .m_data_addr_o(m_addr), .m_data_we_o(m_we),
    .m_data_be_o(m_be), .m_data_wdata_o(m_wdata),
    .m_data_gnt_i(m_gnt), .m_data_rvalid_i(m_rvalid), .m_data_rdata_i(m_rdata),
    .outstanding_o(outst), .protocol_err_o(perr)
  );

  cv32e_obi_port_mux #(.ARB_MODE(0)) dut_fp (
    .clk_i(clk), .rst_ni(rst_n),
    .s_req_i(s_req), .s_addr_i(s_addr), .s_we_i(s_we), .s_be_i(s_be), .s_wdata_i(s_wdata),
    .s_gnt_o(fp_gnt), .s_rvalid_o(fp_rvalid), .s_rdata_o(fp_rdata),
    .m_data_req_o(fp_req), .m_data_addr_o(fp_addr), .m_data_we_o(fp_we),
    .m_data_be_o(fp_be), .m_data_wdata_o(fp_wdata),
    .m_data_gnt_i(m_gnt), .m_data_rvalid_i(m_rvalid), .m_data_rdata_i(m_rdata),
    .outstanding_o(fp_outst), .protocol_err_o(fp_perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 4 units later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [1:0] r, input int p);
    for (int k = 0; k < 2; k++)
      if (r[(p + k) % 2]) return (p + k) % 2;
    return -1;
  endfunction

  int          q[$];
  int          mptr, w, ngrant, cycles;
  logic [1:0]  r, exp_g, exp_rv;
  logic        rv;

  initial begin
    rst_n = 1'b0; s_req = '0; s_addr = '0; s_we = '0; s_be = '0; s_wdata = '0;
    m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    #3;
    chk("reset_outstanding", outst, 0);
    chk("reset_m_req", m_req, 0);
    chk("reset_gnt", gnt, 0);
    chk("reset_rvalid", rvalid, 0);
    chk("reset_perr", perr, 0);
    cyc(); cyc();
    rst_n = 1'b1;

    // single read-only port transaction
    cyc();
    s_req = 2'b01; s_addr[31:0] = 32'h1000; s_we = 2'b01; s_be[3:0] = 4'h3;
    s_wdata[31:0] = 32'h55; m_gnt = 1'b1;
    #4;
    chk("single_m_req", m_req, 1);
    chk("single_gnt", gnt, 2'b01);
    chk("single_addr", m_addr, 32'h1000);
    chk("single_ro_we", m_we, 0);
    chk("single_ro_be", m_be, 4'hF);
    chk("single_ro_wdata", m_wdata, 0);
    cyc();
    s_req = 2'b00; m_gnt = 1'b0;
    #4 chk("single_outst", outst, 1);
    cyc();
    m_rvalid = 1'b1; m_rdata = 32'hDEADBEEF;
    #4;
    chk("single_rvalid", rvalid, 2'b01);
    chk("single_rdata", rdata, 32'hDEADBEEF);
    cyc();
    m_rvalid = 1'b0;
    #4 chk("single_drained", outst, 0);

    // contention: RR pointer sits at port1 after the port0 grant
    cyc();
    s_req = 2'b11; s_addr[63:32] = 32'h2000; s_we = 2'b11; s_be[7:4] = 4'h3;
    s_wdata[63:32] = 32'hCAFE; m_gnt = 1'b1;
    #4;
    chk("rr_gnt0", gnt, 2'b10);
    chk("rr_rw_we", m_we, 1);
    chk("rr_rw_be", m_be, 4'h3);
    chk("rr_rw_wdata", m_wdata, 32'hCAFE);
    chk("fp_gnt0", fp_gnt, 2'b01);
    cyc(); #4 chk("rr_gnt1", gnt, 2'b01); chk("fp_gnt1", fp_gnt, 2'b01);
    cyc(); #4 chk("rr_gnt2", gnt, 2'b10); chk("fp_gnt2", fp_gnt, 2'b01);
    cyc(); #4 chk("rr_gnt3", gnt, 2'b01); chk("fp_gnt3", fp_gnt, 2'b01);

    // backpressure: FIFO full
    cyc(); #4;
    chk("full_outst", outst, 4);
    chk("full_m_req", m_req, 0);
    chk("full_gnt", gnt, 0);
    cyc();
    m_rvalid = 1'b1; m_rdata = 32'h11;
    #4;
    chk("full_pop_no_req", m_req, 0);
    chk("full_pop_route", rvalid, 2'b10);
    cyc();
    s_req = 2'b00; m_rvalid = 1'b0;
    #4 chk("after_pop_outst", outst, 3);
    cyc();
    s_req = 2'b01;
    #4;
    chk("resume_m_req", m_req, 1);
    chk("resume_gnt", gnt, 2'b01);
    cyc();
    s_req = 2'b00; m_rvalid = 1'b1;
    #4 chk("drain_a", rvalid, 2'b01);
    cyc(); #4 chk("drain_b", rvalid, 2'b10);

    // simultaneous push and pop at occupancy 2
    cyc();
    s_req = 2'b10;
    #4;
    chk("pp_outst_before", outst, 2);
    chk("pp_gnt", gnt, 2'b10);
    chk("pp_rvalid", rvalid, 2'b01);
    cyc();
    s_req = 2'b00;
    #4;
    chk("pp_outst_after", outst, 2);
    chk("pp_drain_a", rvalid, 2'b01);
    cyc(); #4 chk("pp_drain_b", rvalid, 2'b10);
    cyc();
    m_rvalid = 1'b0;
    #4 chk("pp_empty", outst, 0);

    // lock: port1 stalls, port0 arrives while RR pointer favours port0
    cyc();
    s_req = 2'b10; s_addr[63:32] = 32'h3000; m_gnt = 1'b0;
    #4;
    chk("lock_addr0", m_addr, 32'h3000);
    chk("lock_gnt0", gnt, 0);
    cyc();
    #4 chk("lock_addr1", m_addr, 32'h3000);
    cyc();
    s_req = 2'b11;
    #4 chk("lock_addr2", m_addr, 32'h3000);
    cyc();
    m_gnt = 1'b1;
    #4;
    chk("lock_gnt_p1", gnt, 2'b10);
    chk("lock_addr3", m_addr, 32'h3000);
    cyc();
    s_req = 2'b01;
    #4;
    chk("lock_gnt_p0", gnt, 2'b01);
    chk("lock_addr_p0", m_addr, 32'h1000);
    cyc();
    s_req = 2'b00; m_rvalid = 1'b1;
    #4 chk("lock_rsp_a", rvalid, 2'b10);
    cyc(); #4 chk("lock_rsp_b", rvalid, 2'b01);
    cyc();
    m_rvalid = 1'b0;

    // reset, then random mixed traffic against an in-order model
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    mptr = 0; ngrant = 0; cycles = 0;
    q.delete();
    while (ngrant < 20 && cycles < 400) begin
      cyc();
      cycles++;
      r  = 2'($urandom_range(0, 3));
      rv = (q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      s_req = r; m_gnt = 1'b1; m_rvalid = rv; m_rdata = $urandom;
      exp_g = '0; w = -1;
      if (r != 2'b00 && q.size() < 4) begin
        w = rr_pick(r, mptr);
        exp_g = 2'(1 << w);
      end
      exp_rv = rv ? 2'(1 << q[0]) : 2'b00;
      #4;
      chk("rnd_outst", outst, 64'(q.size()));
      chk("rnd_gnt", gnt, exp_g);
      chk("rnd_rvalid", rvalid, exp_rv);
      chk("rnd_rdata", rdata, m_rdata);
      if (rv) void'(q.pop_front());
      if (w >= 0) begin
        q.push_back(w);
        mptr = (w + 1) % 2;
        ngrant++;
      end
    end
    chk("rnd_enough_grants", 64'(ngrant >= 20), 1);
    while (q.size() > 0) begin
      cyc();
      s_req = 2'b00; m_rvalid = 1'b1;
      exp_rv = 2'(1 << q[0]);
      #4 chk("rnd_drain", rvalid, exp_rv);
      void'(q.pop_front());
    end
    cyc();
    m_rvalid = 1'b0;
    #4 chk("rnd_empty", outst, 0);

    // stray rvalid with empty FIFO
    chk("perr_before", perr, 0);
    cyc();
    m_rvalid = 1'b1;
    #4 chk("stray_no_rvalid", rvalid, 0);
    cyc();
    m_rvalid = 1'b0;
    #4 chk("perr_set", perr, 1);
    cyc(); cyc();
    #4 chk("perr_sticky", perr, 1);

    // async reset mid-burst
    cyc();
    s_req = 2'b01; m_gnt = 1'b1;
    cyc(); cyc();
    #2 chk("burst_outst", outst, 2);
    rst_n = 1'b0;
    #1;
    chk("async_rst_outst", outst, 0);
    chk("async_rst_perr", perr, 0);
    chk("async_rst_m_req", m_req, 1);
    s_req = 2'b00; m_gnt = 1'b0;
    #1 chk("async_rst_gnt", gnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
